// File: rtl/midi_pkg.sv
// Shared constants and types for the drum kit MIDI OUT note transmitter.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_ON         = 8'h90;
  localparam int         DEFAULT_CLKS_PER_BIT = 3200;
  localparam logic [3:0] DRUM_CHANNEL         = 4'd9;

  typedef struct packed {
    logic [6:0] key;
    logic [6:0] velocity;
  } note_event_t;

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    KEY,
    VEL
  } tx_state_e;

  // MIDI data bytes carry a 7-bit value with the MSB forced low.
  function automatic logic [7:0] data_byte(input logic [6:0] value);
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serialiser, LSB first; byte_done_o marks the last cycle of the stop bit,
// and a new byte may be loaded in that same cycle so consecutive bytes run gap-free.
module midi_uart_tx #(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       idle_o,
  output logic       byte_done_o
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'd8;
  localparam logic [3:0]       STOP_BIT  = 4'd9;

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic             bit_end;
  logic             accept;

  assign bit_end     = busy_q && (baud_q == BAUD_LAST);
  assign byte_done_o = bit_end && (bit_q == STOP_BIT);
  assign accept      = load_i && (!busy_q || byte_done_o);
  assign idle_o      = !busy_q;
  assign tx_o        = tx_q;

  // bit_q: 0 = start bit, 1..8 = data bits d[0]..d[7], 9 = stop bit.
  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    data_d = data_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    if (accept) begin
      busy_d = 1'b1;
      data_d = data_i;
      bit_d  = '0;
      baud_d = '0;
      tx_d   = 1'b0;
    end else if (byte_done_o) begin
      busy_d = 1'b0;
      bit_d  = '0;
      baud_d = '0;
      tx_d   = 1'b1;
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      tx_d   = (bit_q == LAST_DATA) ? 1'b1 : data_q[bit_q[2:0]];
    end else if (busy_q) begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      data_q <= '0;
      bit_q  <= '0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      data_q <= data_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
    end
  end

endmodule

// File: rtl/midi_note_tx.sv
// MIDI OUT Note On transmitter: event FIFO, status/key/velocity sequencer, 8N1 serialiser.
// Running status (repeated status byte suppression) is enabled by MIDI_TX_RUNNING_STATUS_EN.
module midi_note_tx
  import midi_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [3:0] MIDI_CHANNEL = DRUM_CHANNEL
`ifdef MIDI_TX_RUNNING_STATUS_EN
  , parameter int       RS_IDLE_CYCLES = 1 << 24
`endif
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [6:0] note_key,
  input  logic [6:0] note_velocity,
  output logic       midi_tx,
  output logic       tx_busy
);

  localparam int               PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       STATUS_BYTE = MIDI_NOTE_ON | {4'h0, MIDI_CHANNEL};

  note_event_t      fifo_mem [FIFO_DEPTH];
  note_event_t      in_event, fifo_head;
  note_event_t      evt_q, evt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  tx_state_e        state_q, state_d;
  logic             ser_load, ser_idle, ser_tx, byte_done;
  logic [7:0]       ser_data;
  logic             skip_status;
  logic             midi_tx_q, tx_busy_q;

  assign in_event   = {note_key, note_velocity};
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign note_ready = (count_q != FULL_COUNT);
  assign push       = note_valid && note_ready;
  assign midi_tx    = midi_tx_q;
  assign tx_busy    = tx_busy_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (push) fifo_mem[wr_ptr_q] <= in_event;
  end

  // state_q names the byte currently on the wire; the next byte is loaded on byte_done
  // so the three bytes of one message leave back-to-back.
  always_comb begin
    state_d  = state_q;
    evt_d    = evt_q;
    pop      = 1'b0;
    ser_load = 1'b0;
    ser_data = '0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && ser_idle) begin
          pop      = 1'b1;
          evt_d    = fifo_head;
          ser_load = 1'b1;
          if (skip_status) begin
            ser_data = data_byte(fifo_head.key);
            state_d  = KEY;
          end else begin
            ser_data = STATUS_BYTE;
            state_d  = STATUS;
          end
        end
      end
      STATUS: begin
        if (byte_done) begin
          ser_load = 1'b1;
          ser_data = data_byte(evt_q.key);
          state_d  = KEY;
        end
      end
      KEY: begin
        if (byte_done) begin
          ser_load = 1'b1;
          ser_data = data_byte(evt_q.velocity);
          state_d  = VEL;
        end
      end
      VEL: begin
        if (byte_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The serialiser output is re-registered, so the line trails the sequencer by one cycle.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      evt_q     <= '0;
      midi_tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      evt_q     <= evt_d;
      midi_tx_q <= ser_tx;
      tx_busy_q <= (count_q != '0) || (state_q != IDLE);
    end
  end

  midi_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i      (clk_100MHz),
    .rst_i      (rst),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .tx_o       (ser_tx),
    .idle_o     (ser_idle),
    .byte_done_o(byte_done)
  );

`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam int              IDLE_W    = $clog2(RS_IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RS_IDLE_CYCLES - 1);

  logic [7:0]        last_status_q, last_status_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              line_idle;
  logic              status_sent;

  assign skip_status = (last_status_q == STATUS_BYTE);
  assign status_sent = pop && !skip_status;
  assign line_idle   = (state_q == IDLE) && (count_q == '0);

  // Forget the running status after a long silence so late-joining receivers resync.
  always_comb begin
    idle_cnt_d    = idle_cnt_q;
    last_status_d = last_status_q;
    if (!line_idle) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_LAST) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      last_status_d = 8'h00;
    end
    if (status_sent) last_status_d = STATUS_BYTE;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      last_status_q <= 8'h00;
      idle_cnt_q    <= '0;
    end else begin
      last_status_q <= last_status_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end
`else
  assign skip_status = 1'b0;
`endif

endmodule
